fifo_stream_reader: RTL

- Read-side consumer for the team's synchronous FIFO, used in Lease Cache memory-controller test benches and datapaths.
- On a start command it drains exactly len_i words from a FIFO read port (rd_en / empty / registered dout).
- It presents those words on a valid/ready stream, buffering through a 2-entry skid buffer, and pulses done when the last word is accepted.

---
 rtl/fifo_stream_reader.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Read-side consumer for the team's synchronous FIFO. A start command drains
// exactly len_i words from the FIFO read port. Each word passes through a
// 2-entry skid buffer onto a valid/ready stream. done_o pulses once after the
// last word has been accepted downstream.
//
// Optional build macro: FIFO_STREAM_READER_TIMEOUT_EN
//   When defined, a stall counter aborts a transfer after TIMEOUT_CYCLES
//   consecutive RUN cycles with no FIFO read and no stream handshake. An abort
//   sets err_o (sticky), flushes the skid buffer and pulses done_o.
//   When undefined, err_o is tied low and RUN waits forever.
//
// Ports:
//   clk_i         clock, all logic on posedge
//   reset_ni      asynchronous active-low reset
//   start_i       begin transfer (sampled in IDLE only)
//   len_i         words to transfer, latched with start_i
//   busy_o        high whenever not IDLE
//   done_o        one-cycle completion pulse
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_en_o  FIFO read request (combinational)
//   fifo_dout_i   FIFO read data, valid the cycle after an accepted read
//   m_valid_o     stream valid
//   m_data_o      stream data (skid buffer head)
//   m_ready_i     downstream ready
//   err_o         timeout flag
module fifo_stream_reader #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic [WIDTH-1:0] fifo_dout_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             err_o
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] issued_q, issued_d;
    logic [LEN_W-1:0] accepted_q, accepted_d;
    logic             inflight_q, inflight_d;
    logic [WIDTH-1:0] buf_q [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    logic       hs;
    logic       wr;
    logic       rd_en;
    logic [2:0] occ;
    logic       credit_ok;
    logic       timeout;

    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = buf_q[head_q];
    assign hs        = m_valid_o && m_ready_i;
    // Data for a read issued last cycle arrives now.
    assign wr        = inflight_q;

    // Occupancy after this cycle. A slot drained by this cycle's handshake is
    // free for the read issued now, which sustains one word per cycle without
    // ever overflowing the two entries.
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, hs};
    assign credit_ok = (occ < 3'd2);

    assign rd_en = (state_q == StRun) && !fifo_empty_i && (issued_q < len_q) && credit_ok;

    assign fifo_rd_en_o = rd_en;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);

`ifdef FIFO_STREAM_READER_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);

    logic [StallW-1:0] stall_q, stall_d;
    logic              err_q, err_d;

    // Fires on the last idle cycle so DONE is entered TIMEOUT_CYCLES cycles
    // after the last activity (or after RUN entry).
    assign timeout = (state_q == StRun) && !rd_en && !hs &&
                     (stall_q == StallW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stall_d = stall_q;
        if ((state_q != StRun) || rd_en || hs) begin
            stall_d = '0;
        end else begin
            stall_d = stall_q + StallW'(1);
        end
        err_d = err_q;
        if ((state_q == StIdle) && start_i) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    // FSM and transfer counters
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d      = len_i;
                    issued_d   = '0;
                    accepted_d = '0;
                    state_d    = (len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rd_en) begin
                    issued_d = issued_q + LEN_W'(1);
                end
                if (hs) begin
                    accepted_d = accepted_q + LEN_W'(1);
                    if (accepted_q + LEN_W'(1) == len_q) begin
                        state_d = StDone;
                    end
                end
                if (timeout) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Skid buffer pointers and occupancy
    always_comb begin
        inflight_d = rd_en;
        head_d     = hs ? ~head_q : head_q;
        tail_d     = wr ? ~tail_q : tail_q;
        case ({wr, hs})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (timeout) begin
            inflight_d = 1'b0;
            head_d     = 1'b0;
            tail_d     = 1'b0;
            count_d    = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (wr && !timeout) begin
                buf_q[tail_q] <= fifo_dout_i;
            end
        end
    end

endmodule
